// File: rtl/icache_fetch_pkg.sv
// Shared definitions for the direct-mapped instruction cache: state encoding,
// default geometry and the pc_addr field positions.
package icache_fetch_pkg;

  localparam int ICACHE_INDEX_BITS  = 4;
  localparam int ICACHE_OFFSET_BITS = 2;

  typedef enum logic {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

  // Lowest pc_addr bit of the index field; the word offset sits just above the byte bits.
  function automatic int index_lsb(input int offset_bits);
    return 2 + offset_bits;
  endfunction

  // Lowest pc_addr bit of the tag field.
  function automatic int tag_lsb(input int index_bits, input int offset_bits);
    return 2 + offset_bits + index_bits;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage for the instruction cache. Writes are synchronous;
// reads are combinational so a lookup completes in the same cycle.
module icache_array
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS,
  parameter int TAG_BITS    = 32 - 2 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_all,
  input  logic                   line_we,
  input  logic                   word_we,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [TAG_BITS-1:0]    wr_tag,
  input  logic [OFFSET_BITS-1:0] wr_offset,
  input  logic [31:0]            wr_data,
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic                   rd_valid,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic [31:0]            rd_data
);

  localparam int LINES       = 1 << INDEX_BITS;
  localparam int WORDS_TOTAL = 1 << (INDEX_BITS + OFFSET_BITS);

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [WORDS_TOTAL];

  // Clear-all takes priority so an invalidate racing a line write leaves the line invalid.
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      valid <= '0;
    end else if (line_we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[wr_index] <= wr_tag;
    end
    if (word_we) begin
      data_mem[{wr_index, wr_offset}] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache in front of instruction memory: zero-latency
// tag-checked hit path, whole-line refill from word 0 over a req/ready handshake.
//
// state         | meaning
// ICACHE_IDLE   | lookup active; a miss latches the line and starts a refill
// ICACHE_REFILL | fetching words 0..N-1 of the latched line; fetch stalled
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS,
  parameter int TAG_BITS    = 32 - 2 - INDEX_BITS - OFFSET_BITS
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] pc_addr,
  input  logic        invalidate,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        miss_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int IDX_LSB = index_lsb(OFFSET_BITS);
  localparam int TAG_LSB = tag_lsb(INDEX_BITS, OFFSET_BITS);
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = '1;

  icache_state_e          state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic                   abort_q, abort_d;
  logic [TAG_BITS-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0]  miss_index_q, miss_index_d;

  logic [OFFSET_BITS-1:0] pc_offset;
  logic [INDEX_BITS-1:0]  pc_index;
  logic [TAG_BITS-1:0]    pc_tag;
  logic                   pc_byte_unused;

  logic                   rd_valid;
  logic [TAG_BITS-1:0]    rd_tag;
  logic [31:0]            rd_data;
  logic                   hit;
  logic                   line_we;
  logic                   word_we;

  assign pc_offset      = pc_addr[IDX_LSB-1:2];
  assign pc_index       = pc_addr[TAG_LSB-1:IDX_LSB];
  assign pc_tag         = pc_addr[31:32-TAG_BITS];
  assign pc_byte_unused = ^pc_addr[1:0];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (CLK),
    .rst      (Reset),
    .clear_all(invalidate),
    .line_we  (line_we),
    .word_we  (word_we),
    .wr_index (miss_index_q),
    .wr_tag   (miss_tag_q),
    .wr_offset(cnt_q),
    .wr_data  (mem_rdata),
    .rd_index (pc_index),
    .rd_offset(pc_offset),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  // Reset masks the hit so the stale pre-edge valid bits never leak out.
  assign hit         = (state_q == ICACHE_IDLE) && !Reset && rd_valid && (rd_tag == pc_tag);
  assign instr_valid = hit;
  assign instr       = hit ? rd_data : 32'h0;
  assign miss_stall  = !hit;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= ICACHE_IDLE;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    abort_d      = abort_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    mem_req      = 1'b0;
    mem_addr     = 32'h0;
    word_we      = 1'b0;
    line_we      = 1'b0;
    case (state_q)
      ICACHE_IDLE: begin
        abort_d = 1'b0;
        if (!hit) begin
          miss_tag_d   = pc_tag;
          miss_index_d = pc_index;
          cnt_d        = '0;
          state_d      = ICACHE_REFILL;
        end
      end
      ICACHE_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_q, miss_index_q, cnt_q, 2'b00};
        if (invalidate) begin
          abort_d = 1'b1;
        end
        if (mem_ready) begin
          word_we = !Reset;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            // An invalidate seen at any point of the refill, including this cycle, discards the line.
            line_we = !Reset && !abort_q && !invalidate;
            abort_d = 1'b0;
            state_d = ICACHE_IDLE;
          end
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

endmodule
